// File: rtl/mpadd_seq.sv
// rtl/mpadd_seq.sv - multi-precision add sequencer over a shared P-bit ripple adder (nbitfa).
// Optional signed-overflow output enabled by defining MPADD_OVF_EN.

module nbitfa #(
  parameter int N = 6
) (
  output logic [N-1:0] sum,
  output logic         cout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);
  always_comb begin
    logic [N:0] c;
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end
endmodule

module mpadd_seq #(
  parameter int P = 6,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [P*K-1:0] a,
  input  logic [P*K-1:0] b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [P*K-1:0] sum,
  output logic           cout
`ifdef MPADD_OVF_EN
  ,
  output logic           ovf
`endif
);
  localparam int W  = P * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [P-1:0]    fa_sum;
  logic            fa_cout;
  logic            last_chunk;
  logic            accept;

  nbitfa #(.N(P)) u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (op_a_q[idx_q*P +: P]),
    .b    (op_b_q[idx_q*P +: P]),
    .cin  (carry_q)
  );

  assign last_chunk = (idx_q == IW'(K - 1));
  assign accept     = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*P +: P] = fa_sum;
        carry_d             = fa_cout;
        if (last_chunk) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef MPADD_OVF_EN
  // Two's-complement overflow judged from the MSB chunk the adder is producing now.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if ((state_q == RUN) && last_chunk) begin
      ovf_d = (op_a_q[W-1] == op_b_q[W-1]) && (fa_sum[P-1] != op_a_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif
endmodule
